alu_16_driver: RTL

Request-side sequencer for the `alu_16` datapath. It accepts one operation at a time over a valid/ready request port and packs two 16-bit operands and a 5-bit selection code onto the ALU input bus. It waits out the ALU's registered latency, captures the 32-bit result, and returns it over a valid/ready response port. It sits between a command source (bus slave, test sequencer) and the ALU, and owns operand stability and result timing.

---
 rtl/alu16_drv_pkg.sv | 24 ++
 rtl/alu_16_driver.sv | 123 ++++++++++++
 2 files changed

// File: rtl/alu16_drv_pkg.sv
// Shared types and constants for the alu_16 request-side driver.
package alu16_drv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } drvState_e;

  localparam logic [1:0] CLASS_ARITH   = 2'b00;
  localparam logic [1:0] CLASS_LOGIC   = 2'b01;
  localparam logic [1:0] CLASS_SHIFT   = 2'b10;
  localparam logic [1:0] CLASS_ILLEGAL = 2'b11;

  localparam int A_MSB = 31;
  localparam int A_LSB = 16;
  localparam int B_MSB = 15;
  localparam int B_LSB = 0;

  function automatic logic isIllegalClass(input logic [4:0] sel);
    return sel[4:3] == CLASS_ILLEGAL;
  endfunction

endpackage

// File: rtl/alu_16_driver.sv
// Sequencer that issues one operation to alu_16, waits out its latency and returns the result.
// Optional build macro ALU16_DRV_CLASS_CHECK_EN answers class-11 requests with an error instead of issuing them.
module alu_16_driver
  import alu16_drv_pkg::*;
#(
  parameter int ALU_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [15:0] req_a,
  input  logic [15:0] req_b,
  input  logic [4:0]  req_sel,
  output logic [31:0] alu_packed_in,
  output logic [4:0]  alu_sel,
  input  logic [31:0] alu_packed_out,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic [4:0]  rsp_sel,
  output logic        rsp_err,
  output logic        busy,
  output logic [15:0] op_count
);

  localparam logic [3:0] LAT_LOAD = 4'(ALU_LATENCY);

  drvState_e   state_q, state_d;
  logic [3:0]  latCnt_q, latCnt_d;
  logic [31:0] aluIn_q, aluIn_d;
  logic [4:0]  aluSel_q, aluSel_d;
  logic [31:0] rspData_q, rspData_d;
  logic [4:0]  rspSel_q, rspSel_d;
  logic        rspErr_q, rspErr_d;
  logic [15:0] opCount_q, opCount_d;
  logic        illegalReq;

`ifdef ALU16_DRV_CLASS_CHECK_EN
  assign illegalReq = isIllegalClass(req_sel);
`else
  assign illegalReq = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    latCnt_d  = latCnt_q;
    aluIn_d   = aluIn_q;
    aluSel_d  = aluSel_q;
    rspData_d = rspData_q;
    rspSel_d  = rspSel_q;
    rspErr_d  = rspErr_q;
    opCount_d = opCount_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          rspSel_d = req_sel;
          rspErr_d = 1'b0;
          // An illegal class skips the ALU entirely, so its bus keeps the previous operands
          if (illegalReq) begin
            rspData_d = '0;
            rspErr_d  = 1'b1;
            state_d   = RESP;
          end else begin
            aluIn_d[A_MSB:A_LSB] = req_a;
            aluIn_d[B_MSB:B_LSB] = req_b;
            aluSel_d             = req_sel;
            latCnt_d             = LAT_LOAD;
            state_d              = WAIT;
          end
        end
      end
      WAIT: begin
        if (latCnt_q == 4'd0) begin
          rspData_d = alu_packed_out;
          state_d   = RESP;
        end else begin
          latCnt_d = latCnt_q - 4'd1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          opCount_d = opCount_q + 16'd1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      latCnt_q  <= '0;
      aluIn_q   <= '0;
      aluSel_q  <= '0;
      rspData_q <= '0;
      rspSel_q  <= '0;
      rspErr_q  <= 1'b0;
      opCount_q <= '0;
    end else begin
      state_q   <= state_d;
      latCnt_q  <= latCnt_d;
      aluIn_q   <= aluIn_d;
      aluSel_q  <= aluSel_d;
      rspData_q <= rspData_d;
      rspSel_q  <= rspSel_d;
      rspErr_q  <= rspErr_d;
      opCount_q <= opCount_d;
    end
  end

  assign req_ready     = (state_q == IDLE) && !rst;
  assign busy          = (state_q != IDLE);
  assign rsp_valid     = (state_q == RESP);
  assign alu_packed_in = aluIn_q;
  assign alu_sel       = aluSel_q;
  assign rsp_data      = rspData_q;
  assign rsp_sel       = rspSel_q;
  assign rsp_err       = rspErr_q;
  assign op_count      = opCount_q;

endmodule
